// File: rtl/lsu_axi_pkg.sv
// Shared types and encodings for the LSU-to-AXI4 initiator.
package lsu_axi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAr,
        StR,
        StWr,
        StB,
        StResp
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam logic [2:0] SZ_B = 3'd0;
    localparam logic [2:0] SZ_H = 3'd1;
    localparam logic [2:0] SZ_W = 3'd2;

endpackage

// File: rtl/lsu_axi_master_if.sv
// AXI4 read/write channels between the LSU initiator and the crossbar.
interface lsu_axi_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);

    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [3:0]          arid;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rlast;
    logic [3:0]          rid;
    logic                rready;

    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [3:0]          awid;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wlast;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic [3:0]          bid;
    logic                bready;

    modport master (
        output araddr, arvalid, arid, arlen, arsize, arburst, rready,
        output awaddr, awvalid, awid, awlen, awsize, awburst,
        output wdata, wstrb, wvalid, wlast, bready,
        input  arready, rdata, rresp, rvalid, rlast, rid,
        input  awready, wready, bresp, bvalid, bid
    );

    modport slave (
        input  araddr, arvalid, arid, arlen, arsize, arburst, rready,
        input  awaddr, awvalid, awid, awlen, awsize, awburst,
        input  wdata, wstrb, wvalid, wlast, bready,
        output arready, rdata, rresp, rvalid, rlast, rid,
        output awready, wready, bresp, bvalid, bid
    );

endinterface

// File: rtl/lsu_load_align.sv
// Combinational load-data aligner: shifts the addressed lane down and
// sign/zero-extends to 32 bits according to access size.
module lsu_load_align
    import lsu_axi_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  size,
    input  logic        uns,
    output logic [31:0] rsp_rdata
);

    logic [31:0] shifted;

    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        rsp_rdata = shifted;
        case (size)
            SZ_B:    rsp_rdata = uns ? {24'd0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    rsp_rdata = uns ? {16'd0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
            SZ_W:    rsp_rdata = shifted;
            // Misaligned or oversized accesses pass the shifted word through.
            default: rsp_rdata = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_axi_master.sv
// Single-outstanding LSU request to single-beat AXI4 read/write initiator,
// with load-data alignment and a one-cycle response pulse.
module lsu_axi_master
    import lsu_axi_pkg::*;
#(
    parameter logic [3:0]  AXI_ID = 4'd1,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    input  logic [2:0]          req_size,
    input  logic                req_unsigned,

    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,

    lsu_axi_master_if.master    axi
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic [2:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [31:0]         load_data;

    lsu_load_align u_align (
        .rdata     (axi.rdata),
        .addr_lo   (addr_q[1:0]),
        .size      (size_q),
        .uns       (uns_q),
        .rsp_rdata (load_data)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        size_d    = size_q;
        uns_d     = uns_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    size_d    = req_size;
                    uns_d     = req_unsigned;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_wen ? StWr : StAr;
                end
            end
            StAr: begin
                if (axi.arready) state_d = StR;
            end
            StR: begin
                if (axi.rvalid) begin
                    rdata_d = load_data;
                    err_d   = (axi.rresp != AXI_RESP_OKAY) | ~axi.rlast | (axi.rid != AXI_ID);
                    state_d = StResp;
                end
            end
            StWr: begin
                // AW and W complete independently, in either order or together.
                aw_done_d = aw_done_q | axi.awready;
                w_done_d  = w_done_q | axi.wready;
                if (aw_done_d && w_done_d) state_d = StB;
            end
            StB: begin
                if (axi.bvalid) begin
                    rdata_d = '0;
                    err_d   = (axi.bresp != AXI_RESP_OKAY) | (axi.bid != AXI_ID);
                    state_d = StResp;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Held low during reset so every non-constant output reads 0.
    assign req_ready = (state_q == StIdle) & ~reset;
    assign rsp_valid = (state_q == StResp);
    assign rsp_err   = (state_q == StResp) & err_q;
    assign rsp_rdata = rdata_q;

    assign axi.araddr  = addr_q;
    assign axi.arvalid = (state_q == StAr);
    assign axi.arid    = AXI_ID;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = size_q;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.rready  = (state_q == StR);

    assign axi.awaddr  = addr_q;
    assign axi.awvalid = (state_q == StWr) & ~aw_done_q;
    assign axi.awid    = AXI_ID;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = size_q;
    assign axi.awburst = AXI_BURST_INCR;

    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = (state_q == StWr) & ~w_done_q;
    assign axi.wlast   = axi.wvalid;
    assign axi.bready  = (state_q == StB);

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
AXI4 initiator that turns the core's single-outstanding load/store requests into single-beat AXI4 read or write bursts toward crossbar/peripheral responders (CLINT, SRAM, UART).
It sits between the LSU stage and the AXI crossbar. It aligns and extends load data, and returns a one-cycle response pulse with an error flag.

Parameters:
AXI_ID, 4'd1, constant ID driven on arid/awid and expected on rid/bid
ADDR_W, 32, address width
DATA_W, 32, data width (fixed 32; other values unsupported)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  LSU request valid
req_ready  output  1  high only in IDLE
req_wen  input  1  1=store, 0=load
req_addr  input  32  byte address
req_wdata  input  32  store data, already lane-aligned
req_wstrb  input  4  store byte strobes
req_size  input  3  0=byte, 1=half, 2=word
req_unsigned  input  1  zero-extend loads when 1
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  32  aligned, extended load data (0 for stores)
rsp_err  output  1  response error flag
araddr / arvalid  output  32 / 1  read address channel
arready  input  1  read address accepted
arid, arlen, arsize, arburst  output  4,8,3,2  AXI_ID, 0, req_size, 2'b01 (INCR)
rdata, rresp, rvalid, rlast, rid  input  32,2,1,1,4  read data channel
rready  output  1  read data accept
awaddr / awvalid  output  32 / 1  write address channel
awready  input  1  write address accepted
awid, awlen, awsize, awburst  output  4,8,3,2  AXI_ID, 0, req_size, 2'b01
wdata, wstrb, wvalid, wlast  output  32,4,1,1  write data; wlast=wvalid
wready  input  1  write data accepted
bresp, bvalid, bid  input  2,1,4  write response channel
bready  output  1  write response accept

Behaviour:
- Reset: state IDLE. All outputs 0, except the constant fields (arid, arlen, arsize, arburst, awid, awlen, awsize, awburst), which are don't-care but driven as listed.
- Registered request: addr, wen, wdata, wstrb, size and unsigned are latched on req_valid & req_ready. All AXI payload outputs come from these registers and are stable while the corresponding valid is high.
- FSM states: IDLE, AR, R, WR, B, RESP.
- IDLE -> AR on an accepted load; IDLE -> WR on an accepted store.
- AR: arvalid=1. On arready, go to R.
- R: rready=1. On rvalid, capture rdata and set err = (rresp!=0) | !rlast | (rid!=AXI_ID), then go to RESP.
- WR: awvalid and wvalid are asserted together. Each valid drops independently after its own handshake (aw_done / w_done flags). Go to B once both are done; handshakes in the same cycle or in either order are legal.
- B: bready=1. On bvalid, set err = (bresp!=0) | (bid!=AXI_ID), then go to B -> RESP.
- RESP: rsp_valid=1 for exactly one cycle, then return to IDLE.
- No back-to-back acceptance in RESP; req_ready is high only in IDLE.
- Valid rule: once asserted, a valid never drops before its ready. Payloads do not change while valid is high.
- Latency with zero-wait responders (arready=1, rvalid combinational):
  - load: accepted T0, arvalid T1, rready T2, rsp_valid T3.
  - store: accepted T0, aw/w T1, bready T2, rsp_valid T3 (if bvalid arrives at T2).
- Load data: shifted = rdata >> (8*addr[1:0]).
  - size 0 -> 8 bits, size 1 -> 16 bits, size 2 -> full word.
  - Extension: sign-extend unless req_unsigned=1.
  - Misaligned half/word is not checked; the shifted value is passed through.
- Store: rsp_rdata=0.
- Reset mid-transaction: FSM goes to IDLE and all valids/readies drop. Any late responder beat is ignored; no rsp_valid is issued for the aborted request.
- Unexpected rvalid or bvalid outside R/B is ignored (ready is low).

Decomposition:
- Shared package lsu_axi_pkg: state enum, AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, size encodings (SZ_B/SZ_H/SZ_W).
- One sub-module, lsu_load_align: purely combinational (rdata, addr[1:0], size, unsigned -> rsp_rdata). It is unit-testable on its own.

Test Plan:
- Word load from 0x02000000, slave returns rdata=0x12345678, rresp=0, rlast=1, rid=1 -> arvalid at T1, rsp_valid at T3 with rsp_rdata=0x12345678, rsp_err=0.
- Signed byte load at addr 0x80000003, rdata=0x80FF0000 -> rsp_rdata=0xFFFFFF80. The same load with req_unsigned=1 -> 0x00000080.
- Store word 0xDEADBEEF, wstrb=4'hF; slave delays awready 3 cycles while wready=1 immediately -> wvalid drops after 1 beat, awvalid holds until awready, single B, rsp_valid once, rsp_err=0.
- Read returning rresp=2'b10 (SLVERR) -> rsp_valid with rsp_err=1. Read returning rid=4'd3 -> rsp_err=1.
- arready held low for 5 cycles -> arvalid/araddr remain stable, req_ready stays 0, and a new req_valid is not accepted.
- Reset asserted while in R with rvalid pending -> next cycle all valids/readies are 0 and state is IDLE; no rsp_valid; a fresh load afterwards completes normally.
